// File: rtl/mining_round_controller.sv
// rtl/mining_round_controller.sv - mining round sequencer: header broadcast, nonce sweep, hit arbitration
// Optional MINER_ROUND_ROBIN_EN: round-robin winner selection instead of lowest-index priority.
module mining_round_controller #(
   parameter int NUM_CORES     = 4,
   parameter int PARTITIONBITS = 2,
   parameter int BROADCAST_CNT = 5,
   parameter int CORE_LATENCY  = 3,
   localparam int SUFFIX_W     = 32 - PARTITIONBITS,
   localparam int IDX_W        = (BROADCAST_CNT > 1) ? $clog2(BROADCAST_CNT) : 1,
   parameter logic [SUFFIX_W-1:0] SWEEP_LAST = '1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   output logic                 bcast_valid_o,
   output logic [IDX_W-1:0]     bcast_idx_o,
   output logic                 sweep_valid_o,
   output logic [SUFFIX_W-1:0]  suffix_o,
   input  logic [NUM_CORES-1:0] core_success_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 success_o,
   output logic [31:0]          nonce_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SWEEP = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Every stage except the oldest; when these are clear the drain finishes this cycle.
   localparam logic [CORE_LATENCY-1:0] YOUNG_MASK =
      CORE_LATENCY'((64'd1 << (CORE_LATENCY - 1)) - 64'd1);

   logic [2:0]                state;
   logic [CORE_LATENCY-1:0]   dl_v;
   logic [SUFFIX_W-1:0]       dl_s [CORE_LATENCY];
   logic [NUM_CORES-1:0]      hits;
   logic                      hit;
   logic                      younger_pending;
   logic [PARTITIONBITS-1:0]  win_idx;

   assign hits = (dl_v[CORE_LATENCY-1] && (state == S_SWEEP || state == S_DRAIN))
                 ? core_success_i : '0;
   assign hit = |hits;
   assign younger_pending = |(dl_v & YOUNG_MASK);

`ifdef MINER_ROUND_ROBIN_EN
   logic [PARTITIONBITS-1:0] rr_ptr;
   logic                     rr_found;

   // Outer loop walks the search order starting at the pointer; inner loop keeps indices constant.
   always_comb begin
      win_idx  = '0;
      rr_found = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         for (int j = 0; j < NUM_CORES; j++) begin
            if (!rr_found && (j == (int'(rr_ptr) + k) % NUM_CORES) && hits[j]) begin
               win_idx  = PARTITIONBITS'(j);
               rr_found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr <= '0;
      end else if (!start_i && hit) begin
         rr_ptr <= (int'(win_idx) == NUM_CORES - 1) ? '0 : win_idx + 1'b1;
      end
   end
`else
   always_comb begin
      win_idx = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (hits[k]) begin
            win_idx = PARTITIONBITS'(k);
         end
      end
   end
`endif

   // Suffix pipeline mirroring the cores; oldest stage lines up with core_success_i.
   always_ff @(posedge clk) begin
      if (!rst || start_i || hit) begin
         dl_v <= '0;
      end else begin
         dl_v[0] <= sweep_valid_o;
         for (int k = 1; k < CORE_LATENCY; k++) begin
            dl_v[k] <= dl_v[k-1];
         end
      end
      dl_s[0] <= suffix_o;
      for (int k = 1; k < CORE_LATENCY; k++) begin
         dl_s[k] <= dl_s[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         bcast_valid_o <= 1'b0;
         bcast_idx_o   <= '0;
         sweep_valid_o <= 1'b0;
         suffix_o      <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         success_o     <= 1'b0;
         nonce_o       <= '0;
      end else begin
         done_o <= 1'b0;
         if (start_i) begin
            // A new block always wins, including over a hit maturing this cycle.
            state         <= S_LOAD;
            bcast_valid_o <= 1'b1;
            bcast_idx_o   <= '0;
            sweep_valid_o <= 1'b0;
            suffix_o      <= '0;
            busy_o        <= 1'b1;
            success_o     <= 1'b0;
            nonce_o       <= '0;
         end else begin
            case (state)
               S_LOAD: begin
                  if (bcast_idx_o == IDX_W'(BROADCAST_CNT - 1)) begin
                     state         <= S_SWEEP;
                     bcast_valid_o <= 1'b0;
                     bcast_idx_o   <= '0;
                     sweep_valid_o <= 1'b1;
                     suffix_o      <= '0;
                  end else begin
                     bcast_idx_o <= bcast_idx_o + 1'b1;
                  end
               end
               S_SWEEP: begin
                  if (hit) begin
                     state         <= S_DONE;
                     sweep_valid_o <= 1'b0;
                     suffix_o      <= '0;
                     done_o        <= 1'b1;
                     success_o     <= 1'b1;
                     nonce_o       <= {win_idx, dl_s[CORE_LATENCY-1]};
                  end else if (suffix_o == SWEEP_LAST) begin
                     state         <= S_DRAIN;
                     sweep_valid_o <= 1'b0;
                     suffix_o      <= '0;
                  end else begin
                     suffix_o <= suffix_o + 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (hit) begin
                     state     <= S_DONE;
                     done_o    <= 1'b1;
                     success_o <= 1'b1;
                     nonce_o   <= {win_idx, dl_s[CORE_LATENCY-1]};
                  end else if (!younger_pending) begin
                     state     <= S_DONE;
                     done_o    <= 1'b1;
                     success_o <= 1'b0;
                     nonce_o   <= '0;
                  end
               end
               S_DONE: begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mining_round_controller.sv
// tb/tb_mining_round_controller.sv - self-checking bench for mining_round_controller
// Honours MINER_ROUND_ROBIN_EN in its reference model when the RTL is built with it.
module tb_mining_round_controller;

   localparam int NC = 4;
   localparam int PB = 2;
   localparam int BC = 5;
   localparam int L  = 3;
   localparam int SW = 30;
   localparam int SL = 15;
   localparam int S0 = BC + 1;

   logic          clk;
   logic          rst;
   logic          start_i;
   logic          bcast_valid_o;
   logic [2:0]    bcast_idx_o;
   logic          sweep_valid_o;
   logic [SW-1:0] suffix_o;
   logic [NC-1:0] core_success_i;
   logic          busy_o;
   logic          done_o;
   logic          success_o;
   logic [31:0]   nonce_o;

   int            tests_run;
   int            tests_failed;
   int            rr;
   logic          last_succ;
   logic [31:0]   last_nonce;

   mining_round_controller #(
      .NUM_CORES(NC),
      .PARTITIONBITS(PB),
      .BROADCAST_CNT(BC),
      .CORE_LATENCY(L),
      .SWEEP_LAST(30'd15)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_i(start_i),
      .bcast_valid_o(bcast_valid_o),
      .bcast_idx_o(bcast_idx_o),
      .sweep_valid_o(sweep_valid_o),
      .suffix_o(suffix_o),
      .core_success_i(core_success_i),
      .busy_o(busy_o),
      .done_o(done_o),
      .success_o(success_o),
      .nonce_o(nonce_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [69:0] obs();
      return {bcast_valid_o, bcast_idx_o, sweep_valid_o, suffix_o, done_o, busy_o, success_o, nonce_o};
   endfunction

   function automatic int pick(input logic [3:0] v);
`ifdef MINER_ROUND_ROBIN_EN
      for (int k = 0; k < NC; k++) begin
         if (v[(rr + k) % NC]) return (rr + k) % NC;
      end
`else
      for (int k = 0; k < NC; k++) begin
         if (v[k]) return k;
      end
`endif
      return 0;
   endfunction

   // Entered mid-cycle (#1 after an edge); this cycle becomes rel 0 carrying the start pulse.
   task automatic run_round(input string name, input int kstar, input logic [3:0] wv, input int stop_rel);
      int            dc, last_sv, win, k, top;
      logic          sv, fin;
      logic [31:0]   exp_nonce;
      logic [69:0]   e;
      win       = (kstar >= 0) ? pick(wv) : 0;
      dc        = (kstar >= 0) ? S0 + kstar + L + 1 : S0 + SL + L + 1;
      last_sv   = (kstar >= 0 && kstar + L < SL) ? S0 + kstar + L : S0 + SL;
      exp_nonce = (kstar >= 0) ? {2'(win), 30'(kstar)} : 32'd0;
      top       = (stop_rel > 0) ? stop_rel : dc + 1;
      start_i = 1'b1;
      core_success_i = 4'($urandom_range(1, 15));
      for (int rel = 1; rel <= top; rel++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         sv  = (rel >= S0) && (rel <= last_sv);
         fin = (rel >= dc);
         e = {rel <= BC, 3'((rel <= BC) ? rel - 1 : 0), sv, 30'(sv ? rel - S0 : 0),
              rel == dc, rel <= dc, fin && (kstar >= 0), fin ? exp_nonce : 32'd0};
         tests_run++;
         if (obs() !== e) begin
            tests_failed++;
            $display("FAIL %s rel=%0d got=%h expected=%h", name, rel, obs(), e);
         end
         k = rel - S0 - L;
         if (k >= 0 && k <= SL && (kstar < 0 || k <= kstar))
            core_success_i = (k == kstar) ? wv : 4'b0000;
         else
            core_success_i = 4'($urandom_range(1, 15));
      end
      if (stop_rel == 0) begin
         last_succ  = (kstar >= 0);
         last_nonce = exp_nonce;
         if (kstar >= 0) rr = (win + 1) % NC;
      end
   endtask

   task automatic idle(input int n);
      logic [69:0] e;
      for (int i = 0; i < n; i++) begin
         start_i = 1'b0;
         core_success_i = 4'($urandom);
         @(posedge clk); #1;
         e = {1'b0, 3'b0, 1'b0, 30'b0, 1'b0, 1'b0, last_succ, last_nonce};
         tests_run++;
         if (obs() !== e) begin
            tests_failed++;
            $display("FAIL idle got=%h expected=%h", obs(), e);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start_i = 1'b0;
      core_success_i = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (obs() !== 70'd0) begin
         tests_failed++;
         $display("FAIL reset got=%h expected=0", obs());
      end
      rst = 1'b1;
      rr = 0;
      last_succ = 1'b0;
      last_nonce = 32'd0;
      idle(3);
   endtask

   task automatic test_simultaneous();
      run_round("simul_1", 3, 4'b1010, 0);
      tests_run++;
      if (nonce_o !== 32'h4000_0003) begin
         tests_failed++;
         $display("FAIL simul_1_nonce got=%h expected=40000003", nonce_o);
      end
      idle(2);
      run_round("simul_2", 3, 4'b1010, 0);
      tests_run++;
`ifdef MINER_ROUND_ROBIN_EN
      if (nonce_o !== 32'hC000_0003) begin
         tests_failed++;
         $display("FAIL simul_2_nonce got=%h expected=c0000003", nonce_o);
      end
`else
      if (nonce_o !== 32'h4000_0003) begin
         tests_failed++;
         $display("FAIL simul_2_nonce got=%h expected=40000003", nonce_o);
      end
`endif
      idle(1);
   endtask

   task automatic test_single_hit();
      run_round("single_hit", 7, 4'b0100, 0);
      tests_run++;
      if ({success_o, nonce_o} !== {1'b1, 32'h8000_0007}) begin
         tests_failed++;
         $display("FAIL single_hit_result got=%b/%h expected=1/80000007", success_o, nonce_o);
      end
      idle(2);
   endtask

   task automatic test_exhaustion();
      run_round("exhaust", -1, 4'b0000, 0);
      tests_run++;
      if ({success_o, nonce_o} !== 33'd0) begin
         tests_failed++;
         $display("FAIL exhaust_result got=%b/%h expected=0/0", success_o, nonce_o);
      end
      idle(2);
      run_round("late_hit", 14, 4'b1001, 0);
      idle(1);
   endtask

   task automatic test_restart();
      run_round("restart_old", 3, 4'b0001, 9);
      run_round("restart_new", 5, 4'b0010, 0);
      idle(2);
   endtask

   task automatic test_reset_midround();
      run_round("rst_old", 5, 4'b1000, 12);
      rst = 1'b0;
      start_i = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (obs() !== 70'd0) begin
         tests_failed++;
         $display("FAIL rst_mid got=%h expected=0", obs());
      end
      rst = 1'b1;
      rr = 0;
      last_succ = 1'b0;
      last_nonce = 32'd0;
      idle(2);
      run_round("rst_clean", 2, 4'b0110, 0);
      idle(1);
   endtask

   task automatic test_random();
      int kstar;
      for (int r = 0; r < 14; r++) begin
         kstar = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, SL));
         run_round("random", kstar, 4'($urandom_range(1, 15)), 0);
         idle($urandom_range(0, 3));
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_simultaneous();
      test_single_hit();
      test_exhaustion();
      test_restart();
      test_reset_midround();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
